// File: rtl/riscv_lsu.sv
// Single-outstanding load/store unit: aligns core requests onto a 32-bit word bus.
// Optional RISCV_LSU_MISALIGN_TRAP_EN: misaligned half/word accesses complete with an error instead of being issued.
module riscv_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        x_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [1:0]  size_q, off_q;
  logic        uns_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept, misalign, wait_to;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ld_data;
  logic [3:0][7:0] rbytes;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign accept  = req_valid && req_ready;
  assign wait_to = (cnt_q == 8'(TIMEOUT - 1));

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane steering for the outgoing write; size 11 behaves as a word.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = req_wdata;
    case (req_size)
      2'b00: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {req_addr[1], 1'b0};
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rbytes = mem_rdata;
  assign ld_b   = rbytes[off_q];
  assign ld_h   = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_data = mem_rdata;
    case (size_q)
      2'b00:   ld_data = {{24{~uns_q & ld_b[7]}}, ld_b};
      2'b01:   ld_data = {{16{~uns_q & ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = misalign ? RESP : REQ;
      REQ:  if (mem_gnt) state_d = mem_we ? RESP : WAIT;
      WAIT: if (mem_rvalid || wait_to) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (x_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      size_q    <= '0;
      off_q     <= '0;
      uns_q     <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          size_q    <= req_size;
          off_q     <= req_addr[1:0];
          uns_q     <= req_unsigned;
          err_q     <= misalign;
          rdata_q   <= '0;
          mem_we    <= req_we;
          mem_be    <= be_d;
          mem_addr  <= {req_addr[31:2], 2'b00};
          mem_wdata <= wdata_d;
        end
        REQ: if (mem_gnt) cnt_q <= '0;
        // rvalid wins over a timeout landing on the same cycle
        WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem_rvalid)   rdata_q <= ld_data;
          else if (wait_to) err_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && !x_reset;
  assign mem_req    = (state_q == REQ);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized bench for riscv_lsu with a lane-arithmetic reference model.
module tb_riscv_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        x_reset, req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  riscv_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .x_reset(x_reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_mis(input logic [1:0] size, input logic [31:0] addr);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    if (size == 2'b01) return addr % 2 != 0;
    if (size >= 2'b10) return addr % 4 != 0;
`endif
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int unsigned lane;
    lane = addr % 4;
    if (size == 2'b00) return 4'(1 << lane);
    if (size == 2'b01) return 4'(3 << (2 * (lane / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'b00) return (wd % 256) * 32'h0101_0101;
    if (size == 2'b01) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [1:0] size, input logic uns,
                                       input logic [31:0] addr, input logic [31:0] word);
    int unsigned lane;
    logic [31:0] v;
    lane = addr % 4;
    if (size == 2'b00) begin
      v = (word >> (8 * lane)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (size == 2'b01) begin
      v = (word >> (16 * (lane / 2))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return word;
  endfunction

  // One full transaction; rv_dly >= TO means memory never answers.
  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int gnt_dly, input int rv_dly, input logic [31:0] rword);
    logic [31:0] exp_d;
    logic        exp_e;
    chk("ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    step();
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
    if (is_mis(size, addr)) begin
      chk("trap_valid", resp_valid, 1);
      chk("trap_err", resp_err, 1);
      chk("trap_rdata", resp_rdata, 0);
      chk("trap_noreq", mem_req, 0);
      step();
      chk("trap_noreq2", mem_req, 0);
      chk("trap_ready", req_ready, 1);
      return;
    end
    for (int i = 0; i <= gnt_dly; i++) begin
      chk("req", mem_req, 1);
      chk("we", mem_we, we);
      chk("be", mem_be, m_be(size, addr));
      chk("addr", mem_addr, addr & 32'hFFFF_FFFC);
      if (we) chk("wdata", mem_wdata, m_wd(size, wd));
      chk("no_resp_req", resp_valid, 0);
      mem_gnt = (i == gnt_dly);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      step();
    end
    mem_gnt = 0; mem_rvalid = 0;
    exp_d = 0; exp_e = 0;
    if (!we) begin
      exp_e = 1;
      for (int k = 0; k < TO; k++) begin
        chk("wait_noreq", mem_req, 0);
        chk("wait_noresp", resp_valid, 0);
        mem_rvalid = (k == rv_dly);
        mem_rdata = (k == rv_dly) ? rword : $urandom;
        step();
        mem_rvalid = 0;
        if (k == rv_dly) begin
          exp_e = 0;
          exp_d = m_ld(size, uns, addr, rword);
          break;
        end
      end
    end
    chk("resp_valid", resp_valid, 1);
    chk("resp_rdata", resp_rdata, exp_d);
    chk("resp_err", resp_err, exp_e);
    step();
    chk("resp_pulse", resp_valid, 0);
  endtask

  initial begin
    x_reset = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    step(); step();
    chk("rst_ready", req_ready, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_resp", resp_valid, 0);
    x_reset = 0;
    step();
    chk("rst_ready_after", req_ready, 1);

    // Directed scenarios
    txn(1, 2'b00, 0, 32'h103, 32'hAB, 0, 0, 0);
    txn(0, 2'b01, 0, 32'h22, 0, 0, 0, 32'h8001_0000);
    txn(0, 2'b00, 1, 32'h1, 0, 3, 1, 32'h1234_C356);
    txn(0, 2'b10, 0, 32'h40, 0, 1, TO, 0);
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 0;
    chk("stray_rvalid", resp_valid, 0);
    txn(0, 2'b10, 0, 32'h6, 0, 0, 0, 32'hCAFE_F00D);
    txn(0, 2'b01, 1, 32'h13, 0, 0, 2, 32'h9ABC_7654);
    txn(1, 2'b11, 0, 32'h201, 32'h1122_3344, 2, 0, 0);

    // Reset while waiting for read data
    req_valid = 1; req_we = 0; req_size = 2'b10; req_addr = 32'h80;
    step();
    req_valid = 0; mem_gnt = 1;
    step();
    mem_gnt = 0;
    chk("rstw_in_wait", mem_req, 0);
    x_reset = 1;
    step();
    chk("rstw_req", mem_req, 0);
    chk("rstw_resp", resp_valid, 0);
    chk("rstw_ready", req_ready, 0);
    x_reset = 0; mem_rvalid = 1; mem_rdata = 32'h5555_5555;
    step();
    mem_rvalid = 0;
    chk("rstw_ready_after", req_ready, 1);
    chk("rstw_resp2", resp_valid, 0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, TO)),
          $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
